// File: rtl/sy_ppl_ras_ctrl.sv
// Return-address-stack sequencer: forwards fetch call/return predictions, keeps a committed shadow
// stack and replays it into the RAS after a redirect. Optional perf counters: SY_RAS_CTRL_PERF_EN.
module sy_ppl_ras_ctrl #(
    parameter int DEPTH = 4,
    parameter int AWTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fe_call_i,
    input  logic                         fe_ret_i,
    input  logic [AWTH-1:0]              fe_ra_i,
    output logic                         fe_rdy_o,
    input  logic                         cmt_call_i,
    input  logic                         cmt_ret_i,
    input  logic [AWTH-1:0]              cmt_ra_i,
    input  logic                         redirect_i,
    output logic                         ras_push_o,
    output logic                         ras_pop_o,
    output logic [AWTH-1:0]              ras_data_o,
    output logic                         ras_flush_o,
    output logic                         busy_o,
`ifdef SY_RAS_CTRL_PERF_EN
    output logic [31:0]                  perf_recov_cnt_o,
    output logic [31:0]                  perf_ovf_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   shadow_cnt_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        REPLAY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AWTH-1:0] shadow_q [DEPTH];
    logic [AWTH-1:0] shadow_d [DEPTH];
    logic            cmt_op;

    assign cmt_op = cmt_call_i | cmt_ret_i;

    // Shadow stack, index 0 is the newest committed return address.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (cmt_call_i && cmt_ret_i) begin
            shadow_d[0] = cmt_ra_i;
            if (cnt_q == '0) begin
                cnt_d = CW'(1);
            end
        end else if (cmt_call_i) begin
            for (int i = 1; i < DEPTH; i++) begin
                shadow_d[i] = shadow_q[i-1];
            end
            shadow_d[0] = cmt_ra_i;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cmt_ret_i && (cnt_q != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                shadow_d[i] = shadow_q[i+1];
            end
            shadow_d[DEPTH-1] = '0;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fe_rdy_o    = 1'b0;
        ras_push_o  = 1'b0;
        ras_pop_o   = 1'b0;
        ras_data_o  = '0;
        ras_flush_o = 1'b0;
        case (state_q)
            IDLE: begin
                fe_rdy_o   = 1'b1;
                ras_push_o = fe_call_i;
                ras_pop_o  = fe_ret_i;
                ras_data_o = fe_ra_i;
                if (redirect_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                ras_flush_o = 1'b1;
                // Oldest entry first, so the newest ends on the RAS top.
                idx_d = IW'(cnt_d - CW'(1));
                if (redirect_i || cmt_op) begin
                    state_d = FLUSH;
                end else if (cnt_d == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                ras_push_o = 1'b1;
                ras_data_o = shadow_q[idx_q];
                if (redirect_i || cmt_op) begin
                    state_d = FLUSH;
                end else if (idx_q == '0) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign shadow_cnt_o = cnt_q;

`ifdef SY_RAS_CTRL_PERF_EN
    logic [31:0] perf_recov_q, perf_recov_d;
    logic [31:0] perf_ovf_q, perf_ovf_d;

    always_comb begin
        perf_recov_d = perf_recov_q;
        perf_ovf_d   = perf_ovf_q;
        if ((state_d == FLUSH) && (perf_recov_q != 32'hFFFF_FFFF)) begin
            perf_recov_d = perf_recov_q + 32'd1;
        end
        if (cmt_call_i && !cmt_ret_i && (cnt_q == CW'(DEPTH)) &&
            (perf_ovf_q != 32'hFFFF_FFFF)) begin
            perf_ovf_d = perf_ovf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_recov_q <= '0;
            perf_ovf_q   <= '0;
        end else begin
            perf_recov_q <= perf_recov_d;
            perf_ovf_q   <= perf_ovf_d;
        end
    end

    assign perf_recov_cnt_o = perf_recov_q;
    assign perf_ovf_cnt_o   = perf_ovf_q;
`endif

endmodule

// File: tb/tb_sy_ppl_ras_ctrl.sv
// Directed bench for sy_ppl_ras_ctrl (DEPTH=4, AWTH=32); perf checks when SY_RAS_CTRL_PERF_EN is set.
module tb_sy_ppl_ras_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fe_call_i, fe_ret_i, cmt_call_i, cmt_ret_i, redirect_i;
    logic [31:0] fe_ra_i, cmt_ra_i;
    logic        fe_rdy_o, ras_push_o, ras_pop_o, ras_flush_o, busy_o;
    logic [31:0] ras_data_o;
    logic [2:0]  shadow_cnt_o;
`ifdef SY_RAS_CTRL_PERF_EN
    logic [31:0] perf_recov_cnt_o, perf_ovf_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    sy_ppl_ras_ctrl #(.DEPTH(4), .AWTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fe_call_i    (fe_call_i),
        .fe_ret_i     (fe_ret_i),
        .fe_ra_i      (fe_ra_i),
        .fe_rdy_o     (fe_rdy_o),
        .cmt_call_i   (cmt_call_i),
        .cmt_ret_i    (cmt_ret_i),
        .cmt_ra_i     (cmt_ra_i),
        .redirect_i   (redirect_i),
        .ras_push_o   (ras_push_o),
        .ras_pop_o    (ras_pop_o),
        .ras_data_o   (ras_data_o),
        .ras_flush_o  (ras_flush_o),
        .busy_o       (busy_o),
`ifdef SY_RAS_CTRL_PERF_EN
        .perf_recov_cnt_o (perf_recov_cnt_o),
        .perf_ovf_cnt_o   (perf_ovf_cnt_o),
`endif
        .shadow_cnt_o (shadow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic rdy, input logic push, input logic pop,
                         input logic flush, input logic busy);
        chk({tag, ".rdy"},   fe_rdy_o,    rdy);
        chk({tag, ".push"},  ras_push_o,  push);
        chk({tag, ".pop"},   ras_pop_o,   pop);
        chk({tag, ".flush"}, ras_flush_o, flush);
        chk({tag, ".busy"},  busy_o,      busy);
    endtask

    // Drive all inputs just after the falling edge, then settle before sampling.
    task automatic drv(input logic fc, input logic fr, input logic [31:0] fra,
                       input logic cc, input logic cr, input logic [31:0] cra, input logic rd);
        @(negedge clk_i);
        fe_call_i  = fc;
        fe_ret_i   = fr;
        fe_ra_i    = fra;
        cmt_call_i = cc;
        cmt_ret_i  = cr;
        cmt_ra_i   = cra;
        redirect_i = rd;
        #1;
    endtask

    task automatic nop();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ccall(input logic [31:0] ra);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, ra, 1'b0);
    endtask

    task automatic chk_push(input string tag, input logic [31:0] ra);
        chk_o(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk({tag, ".data"}, ras_data_o, ra);
    endtask

    initial begin
        rst_i = 1'b0;
        fe_call_i = 1'b0; fe_ret_i = 1'b0; fe_ra_i = '0;
        cmt_call_i = 1'b0; cmt_ret_i = 1'b0; cmt_ra_i = '0; redirect_i = 1'b0;
        @(negedge clk_i); #1;
        chk_o("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.cnt", shadow_cnt_o, 3'd0);
        chk("reset.data", ras_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fetch forwarding in IDLE
        drv(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_o("fe_call", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fe_call.data", ras_data_o, 32'h100);
        drv(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_o("fe_ret", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        nop();
        chk("fe_ops.cnt", shadow_cnt_o, 3'd0);

        // Commit A,B,C then redirect with a fetch call in the same cycle
        ccall(32'hA); ccall(32'hB); ccall(32'hC);
        drv(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("abc.cnt", shadow_cnt_o, 3'd3);
        chk_o("abc.redir", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("abc.redir.data", ras_data_o, 32'h55);
        nop();
        chk_o("abc.flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_push("abc.r0", 32'hA);
        nop(); chk_push("abc.r1", 32'hB);
        nop(); chk_push("abc.r2", 32'hC);
        nop(); chk_o("abc.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Drain with commit returns, plus one return on empty
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("ret.cnt1", shadow_cnt_o, 3'd1);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("ret.cnt0", shadow_cnt_o, 3'd0);
        nop();
        chk("ret.empty.cnt", shadow_cnt_o, 3'd0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        nop(); chk_o("empty.flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(); chk_o("empty.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overflow: five calls into a 4-deep shadow
        ccall(32'h1); ccall(32'h2); ccall(32'h3); ccall(32'h4); ccall(32'h5);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("ovf.cnt", shadow_cnt_o, 3'd4);
`ifdef SY_RAS_CTRL_PERF_EN
        chk("ovf.perf_ovf", perf_ovf_cnt_o, 32'd1);
`endif
        nop(); chk_o("ovf.flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(); chk_push("ovf.r0", 32'h2);
        nop(); chk_push("ovf.r1", 32'h3);
        nop(); chk_push("ovf.r2", 32'h4);
        nop(); chk_push("ovf.r3", 32'h5);
        nop(); chk_o("ovf.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SY_RAS_CTRL_PERF_EN
        chk("ovf.perf_recov", perf_recov_cnt_o, 32'd3);
`endif

        // Reset in the middle of a replay
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        nop();
        nop(); chk_push("rst.r0", 32'h2);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_o("rst.low", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_o("rst.rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", shadow_cnt_o, 3'd0);
`ifdef SY_RAS_CTRL_PERF_EN
        chk("rst.perf_recov", perf_recov_cnt_o, 32'd0);
`endif

        // Commit during replay restarts recovery with current contents
        ccall(32'hA); ccall(32'hB);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        nop(); chk_o("rs.flush0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(); chk_push("rs.r0", 32'hA);
        ccall(32'hD); chk_push("rs.r1", 32'hB);
        nop(); chk_o("rs.flush1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rs.cnt", shadow_cnt_o, 3'd3);
        nop(); chk_push("rs.r2", 32'hA);
        nop(); chk_push("rs.r3", 32'hB);
        nop(); chk_push("rs.r4", 32'hD);
        nop(); chk_o("rs.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SY_RAS_CTRL_PERF_EN
        chk("rs.perf_recov", perf_recov_cnt_o, 32'd2);
`endif

        // Simultaneous commit call+ret overwrites the top without shifting
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("cr.cnt", shadow_cnt_o, 3'd3);
        nop(); chk_o("cr.flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(); chk_push("cr.r0", 32'hA);
        nop(); chk_push("cr.r1", 32'hB);
        nop(); chk_push("cr.r2", 32'hE);
        nop(); chk_o("cr.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
